// File: rtl/config_pkg.sv
// Core configuration record and per-thread context status type
// shared by the thread scheduler and its context storage.
package config_pkg;

    typedef struct packed {
        int unsigned NUM_THREADS;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NUM_THREADS: 32'd4, VLEN: 32'd32};

    typedef enum logic [1:0] {
        THREAD_HALTED  = 2'd0,
        THREAD_READY   = 2'd1,
        THREAD_BLOCKED = 2'd2
    } thread_status_t;

endpackage

// File: rtl/thread_scheduler.sv
// Round-robin hardware thread scheduler: dispatches READY threads to the frontend,
// time-slices them with a quantum counter and drains the active thread on preemption or halt.
module thread_scheduler #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NUM_THREADS = CVA6Cfg.NUM_THREADS,
    parameter int unsigned           QUANTUM     = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  config_pkg::thread_status_t         all_threads_status_i [NUM_THREADS],
    output logic [$clog2(NUM_THREADS)-1:0]     pc_read_thread_id_o,
    input  logic [CVA6Cfg.VLEN-1:0]            pc_read_value_i,
    output logic                               pc_write_o,
    output logic [$clog2(NUM_THREADS)-1:0]     pc_write_thread_id_o,
    output logic [CVA6Cfg.VLEN-1:0]            pc_write_value_o,
    output logic                               thread_status_update_o,
    output logic [$clog2(NUM_THREADS)-1:0]     thread_status_update_id_o,
    output config_pkg::thread_status_t         thread_status_value_o,
    output logic                               switch_req_o,
    output logic [$clog2(NUM_THREADS)-1:0]     switch_thread_id_o,
    output logic [CVA6Cfg.VLEN-1:0]            switch_pc_o,
    input  logic                               switch_ack_i,
    output logic                               drain_req_o,
    input  logic                               save_pc_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]            save_pc_i,
    input  logic                               halt_req_i,
    input  logic                               wake_req_i,
    input  logic [$clog2(NUM_THREADS)-1:0]     wake_id_i,
    output logic                               wake_ack_o,
    output logic                               active_valid_o,
    output logic [$clog2(NUM_THREADS)-1:0]     active_thread_id_o
);

    localparam int unsigned   TW         = $clog2(NUM_THREADS);
    localparam int unsigned   CW         = $clog2(QUANTUM);
    localparam logic [TW-1:0] LAST_RESET = TW'(NUM_THREADS - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(QUANTUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        RUN,
        DRAIN,
        SELECT
    } state_e;

    state_e        state_q;
    logic [TW-1:0] last_id_q;
    logic [TW-1:0] sel_id_q;
    logic [TW-1:0] active_id_q;
    logic [CW-1:0] cnt_q;
    logic          halt_pending_q;
    logic          active_valid_q;
    logic          switch_req_q;
    logic          drain_req_q;

    logic [TW-1:0] rr_id_d;
    logic [TW-1:0] cand_id;
    logic          rr_found;
    logic          other_ready;
    logic          save_fire;
    logic          halt_write;

    // Search starts just after the last active thread, so that thread is considered last.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rr_id_d     = '0;
        cand_id     = '0;
        rr_found    = 1'b0;
        other_ready = 1'b0;
        for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
            cand_id = TW'((32'(last_id_q) + i) % NUM_THREADS);
            if (all_threads_status_i[cand_id] == config_pkg::THREAD_READY) begin
                if (!rr_found) begin
                    rr_id_d  = cand_id;
                    rr_found = 1'b1;
                end
                if (i < NUM_THREADS) begin
                    other_ready = 1'b1;
                end
            end
        end
    end

    assign save_fire  = (state_q == DRAIN) && save_pc_valid_i;
    assign halt_write = save_fire && halt_pending_q;

    // A halt status write owns the status port; a colliding wake is held off by the requester.
    assign wake_ack_o                = wake_req_i && !halt_write;
    assign thread_status_update_o    = halt_write || wake_req_i;
    assign thread_status_update_id_o = halt_write ? active_id_q : (wake_req_i ? wake_id_i : '0);
    assign thread_status_value_o     = halt_write ? config_pkg::THREAD_HALTED
                                                  : config_pkg::THREAD_READY;

    assign pc_write_o           = save_fire;
    assign pc_write_thread_id_o = active_id_q;
    assign pc_write_value_o     = save_pc_i;

    assign pc_read_thread_id_o = sel_id_q;
    assign switch_thread_id_o  = sel_id_q;
    assign switch_pc_o         = pc_read_value_i;
    assign switch_req_o        = switch_req_q;
    assign drain_req_o         = drain_req_q;
    assign active_valid_o      = active_valid_q;
    assign active_thread_id_o  = active_id_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            last_id_q      <= LAST_RESET;
            sel_id_q       <= '0;
            active_id_q    <= '0;
            cnt_q          <= '0;
            halt_pending_q <= 1'b0;
            active_valid_q <= 1'b0;
            switch_req_q   <= 1'b0;
            drain_req_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, SELECT: begin
                    if (rr_found) begin
                        sel_id_q     <= rr_id_d;
                        switch_req_q <= 1'b1;
                        state_q      <= DISPATCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DISPATCH: begin
                    if (switch_ack_i) begin
                        switch_req_q   <= 1'b0;
                        active_valid_q <= 1'b1;
                        active_id_q    <= sel_id_q;
                        last_id_q      <= sel_id_q;
                        cnt_q          <= CNT_RELOAD;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    if (halt_req_i) begin
                        halt_pending_q <= 1'b1;
                        drain_req_q    <= 1'b1;
                        state_q        <= DRAIN;
                    end else if (cnt_q == '0) begin
                        if (other_ready) begin
                            drain_req_q <= 1'b1;
                            state_q     <= DRAIN;
                        end else begin
                            cnt_q <= CNT_RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (save_pc_valid_i) begin
                        drain_req_q    <= 1'b0;
                        active_valid_q <= 1'b0;
                        halt_pending_q <= 1'b0;
                        state_q        <= SELECT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler (4 threads, quantum 8): a per-cycle vector table
// against a small context-storage model, plus hand sequences for dispatch stall and reset.
module tb_thread_scheduler;
    import config_pkg::*;

    localparam int unsigned NT = 4;

    logic           clk;
    logic           rst_n;
    thread_status_t ctx_status [NT];
    logic [31:0]    ctx_pc [NT];
    logic           preset_en;

    logic [1:0]     pc_read_id;
    logic [31:0]    pc_read_value;
    logic           pc_write;
    logic [1:0]     pc_write_id;
    logic [31:0]    pc_write_value;
    logic           st_upd;
    logic [1:0]     st_id;
    thread_status_t st_val;
    logic           switch_req;
    logic [1:0]     switch_id;
    logic [31:0]    switch_pc;
    logic           switch_ack;
    logic           drain_req;
    logic           save_pc_valid;
    logic [31:0]    save_pc;
    logic           halt_req;
    logic           wake_req;
    logic [1:0]     wake_id;
    logic           wake_ack;
    logic           active_valid;
    logic [1:0]     active_id;

    thread_scheduler #(
        .NUM_THREADS(NT),
        .QUANTUM    (8)
    ) dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .all_threads_status_i     (ctx_status),
        .pc_read_thread_id_o      (pc_read_id),
        .pc_read_value_i          (pc_read_value),
        .pc_write_o               (pc_write),
        .pc_write_thread_id_o     (pc_write_id),
        .pc_write_value_o         (pc_write_value),
        .thread_status_update_o   (st_upd),
        .thread_status_update_id_o(st_id),
        .thread_status_value_o    (st_val),
        .switch_req_o             (switch_req),
        .switch_thread_id_o       (switch_id),
        .switch_pc_o              (switch_pc),
        .switch_ack_i             (switch_ack),
        .drain_req_o              (drain_req),
        .save_pc_valid_i          (save_pc_valid),
        .save_pc_i                (save_pc),
        .halt_req_i               (halt_req),
        .wake_req_i               (wake_req),
        .wake_id_i                (wake_id),
        .wake_ack_o               (wake_ack),
        .active_valid_o           (active_valid),
        .active_thread_id_o       (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Context storage: registered writes, combinational PC read.
    assign pc_read_value = ctx_pc[pc_read_id];
    always @(posedge clk) begin
        if (preset_en) begin
            ctx_status <= '{THREAD_READY, THREAD_HALTED, THREAD_HALTED, THREAD_HALTED};
            for (int i = 0; i < NT; i++) ctx_pc[i] <= 32'h8000_0000 + 32'(i) * 32'h1000;
        end else begin
            if (pc_write) ctx_pc[pc_write_id] <= pc_write_value;
            if (st_upd) ctx_status[st_id] <= st_val;
        end
    end

    typedef struct {
        logic           ack, spv, halt, wake;
        logic [31:0]    spc;
        logic [1:0]     wid;
        logic           e_swreq;
        logic [1:0]     e_swid;
        logic [31:0]    e_swpc;
        logic           e_drain, e_pcw, e_st;
        logic [1:0]     e_stid;
        thread_status_t e_stval;
        logic           e_actv;
        logic [1:0]     e_actid;
        logic           e_wack;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic add(input logic ack, input logic spv, input logic [31:0] spc, input logic halt,
                       input logic wake, input logic [1:0] wid, input logic e_swreq,
                       input logic [1:0] e_swid, input logic [31:0] e_swpc, input logic e_drain,
                       input logic e_pcw, input logic e_st, input logic [1:0] e_stid,
                       input thread_status_t e_stval, input logic e_actv, input logic [1:0] e_actid,
                       input logic e_wack);
        vec_t v;
        v.ack = ack; v.spv = spv; v.spc = spc; v.halt = halt; v.wake = wake; v.wid = wid;
        v.e_swreq = e_swreq; v.e_swid = e_swid; v.e_swpc = e_swpc; v.e_drain = e_drain;
        v.e_pcw = e_pcw; v.e_st = e_st; v.e_stid = e_stid; v.e_stval = e_stval;
        v.e_actv = e_actv; v.e_actid = e_actid; v.e_wack = e_wack;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        switch_ack = 1'b0; save_pc_valid = 1'b0; save_pc = '0;
        halt_req = 1'b0; wake_req = 1'b0; wake_id = '0;
    endtask

    initial begin
        logic [79:0] got;
        logic [79:0] want;
        vec_t        v;

        rst_n = 1'b0;
        preset_en = 1'b1;
        drive_idle();

        // Thread 0 boots: dispatch, then two full quanta with no other READY thread.
        add(1,0,0,0,0,0, 1,0,32'h8000_0000, 0,0,0,0,THREAD_READY, 0,0,0);
        for (int i = 0; i < 16; i++) add(0,0,0,0,0,0, 0,0,0, 0,0,0,0,THREAD_READY, 1,0,0);
        // Wake thread 2; quantum expiry then preempts thread 0.
        add(0,0,0,0,1,2, 0,0,0, 0,0,1,2,THREAD_READY, 1,0,1);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0,0, 0,0,0, 0,0,0,0,THREAD_READY, 1,0,0);
        add(0,0,0,0,0,0,               0,0,0,            1,0,0,0,THREAD_READY,  1,0,0);
        add(0,1,32'h8000_0040,0,0,0,   0,0,0,            1,1,0,0,THREAD_READY,  1,0,0);
        add(0,0,0,1,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  0,0,0);
        add(1,0,0,0,0,0,               1,2,32'h8000_2000,0,0,0,0,THREAD_READY,  0,0,0);
        // Thread 2 halts; a wake of thread 1 collides with the HALTED write and is retried.
        add(0,0,0,1,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  1,2,0);
        add(0,0,0,0,0,0,               0,0,0,            1,0,0,0,THREAD_READY,  1,2,0);
        add(0,1,32'h8000_2100,0,1,1,   0,0,0,            1,1,1,2,THREAD_HALTED, 1,2,0);
        add(0,0,0,0,1,1,               0,0,0,            0,0,1,1,THREAD_READY,  0,2,1);
        add(1,0,0,0,0,0,               1,0,32'h8000_0040,0,0,0,0,THREAD_READY,  0,2,0);
        // Thread 0 halts, thread 1 runs and halts, leaving nothing READY.
        add(0,0,0,1,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  1,0,0);
        add(0,1,32'h8000_0080,0,0,0,   0,0,0,            1,1,1,0,THREAD_HALTED, 1,0,0);
        add(0,0,0,0,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  0,0,0);
        add(1,0,0,0,0,0,               1,1,32'h8000_1000,0,0,0,0,THREAD_READY,  0,0,0);
        add(0,0,0,1,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  1,1,0);
        add(0,1,32'h8000_0100,0,0,0,   0,0,0,            1,1,1,1,THREAD_HALTED, 1,1,0);
        add(0,0,0,0,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  0,1,0);
        // Idle: wake thread 3 (halt ignored here), dispatch two cycles later, ack withheld.
        add(0,0,0,1,1,3,               0,0,0,            0,0,1,3,THREAD_READY,  0,1,1);
        add(0,0,0,1,0,0,               0,0,0,            0,0,0,0,THREAD_READY,  0,1,0);
        add(0,0,0,0,0,0,               1,3,32'h8000_3000,0,0,0,0,THREAD_READY,  0,1,0);

        repeat (3) @(negedge clk);
        preset_en = 1'b0;
        #1;
        check("reset_strobes", 128'({switch_req, drain_req, pc_write, st_upd, active_valid, wake_ack}), 128'(0));
        check("reset_ids", 128'({pc_read_id, switch_id, pc_write_id, st_id, active_id}), 128'(0));
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            v = vecs[k];
            switch_ack = v.ack; save_pc_valid = v.spv; save_pc = v.spc;
            halt_req = v.halt; wake_req = v.wake; wake_id = v.wid;
            #1;
            got  = {switch_req, switch_req ? {switch_id, switch_pc} : 34'h0, drain_req,
                    pc_write, pc_write ? {pc_write_id, pc_write_value} : 34'h0,
                    st_upd, st_upd ? {st_id, 2'(st_val)} : 4'h0, active_valid, active_id, wake_ack};
            want = {v.e_swreq, v.e_swreq ? {v.e_swid, v.e_swpc} : 34'h0, v.e_drain,
                    v.e_pcw, v.e_pcw ? {v.e_actid, v.spc} : 34'h0,
                    v.e_st, v.e_st ? {v.e_stid, 2'(v.e_stval)} : 4'h0, v.e_actv, v.e_actid, v.e_wack};
            check($sformatf("vec%0d", k), 128'(got), 128'(want));
        end

        // Dispatch stalled on ack: request, id and pc hold steady.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            #1;
            check($sformatf("stall%0d", i), 128'({switch_req, switch_id, switch_pc}), 128'({1'b1, 2'd3, 32'h8000_3000}));
        end

        // Reset during DISPATCH abandons it without writes.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_dispatch", 128'({switch_req, drain_req, pc_write, st_upd, active_valid}), 128'(0));
        @(negedge clk);
        #1;
        check("rst_dispatch_hold", 128'({pc_write, st_upd, 2'(ctx_status[3])}), 128'({2'b00, 2'(THREAD_READY)}));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("redispatch3", 128'({switch_req, switch_id, switch_pc}), 128'({1'b1, 2'd3, 32'h8000_3000}));
        switch_ack = 1'b1;
        @(negedge clk);
        switch_ack = 1'b0;
        halt_req = 1'b1;
        #1;
        check("run3", 128'({active_valid, active_id, switch_req}), 128'({1'b1, 2'd3, 1'b0}));
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        check("drain3", 128'({drain_req, pc_write, st_upd}), 128'(3'b100));

        // Reset during DRAIN abandons it: no PC or HALTED write, thread 3 stays READY.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_drain", 128'({drain_req, pc_write, st_upd, active_valid}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_drain_status", 128'({2'(ctx_status[3]), ctx_pc[3]}), 128'({2'(THREAD_READY), 32'h8000_3000}));
        @(negedge clk);
        #1;
        check("redispatch3b", 128'({switch_req, switch_id}), 128'({1'b1, 2'd3}));
        switch_ack = 1'b1;
        @(negedge clk);
        switch_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("solo%0d", i), 128'({active_valid, active_id, drain_req}), 128'({1'b1, 2'd3, 1'b0}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
